// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the parametrised raster timing generator.
// Default geometry is the classic 256x256 raster in a 320x288 frame.
package video_timing_pkg;

  typedef enum logic [1:0] {
    PAT_PASS  = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRID  = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_t;

  localparam int unsigned DEF_H_DISPLAY = 256;
  localparam int unsigned DEF_H_FP      = 8;
  localparam int unsigned DEF_H_PULSE   = 40;
  localparam int unsigned DEF_H_BP      = 16;
  localparam int unsigned DEF_V_DISPLAY = 256;
  localparam int unsigned DEF_V_FP      = 8;
  localparam int unsigned DEF_V_PULSE   = 8;
  localparam int unsigned DEF_V_BP      = 16;

  // Stage-0 timing bundle carried through the delay line alongside the core latency.
  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       hblank;
    logic       vblank;
    logic       de;
    logic       border;
    logic [2:0] bar;
    logic [3:0] x_lo;
    logic [3:0] y_lo;
    logic       line_start;
    logic       frame_start;
  } timing_t;

  // Replicate a bits-wide colour MSB-first across 8 bits (4 bits -> {c,c}).
  function automatic logic [7:0] expand_color(input logic [7:0] value, input int unsigned bits);
    logic [7:0]  res;
    logic [2:0]  src;
    int unsigned n;
    n   = (bits == 0) ? 1 : ((bits > 8) ? 8 : bits);
    res = '0;
    for (int i = 0; i < 8; i++) begin
      src           = 3'(n - 1 - (i % n));
      res[3'(7 - i)] = value[src];
    end
    return res;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel request/response and video output bundle between core, generator and mixer.
interface video_timing_gen_if #(
  parameter int unsigned CW         = 12,
  parameter int unsigned COLOR_BITS = 4
);

  logic [CW-1:0]         x;
  logic [CW-1:0]         y;
  logic                  req;
  logic [COLOR_BITS-1:0] r_in;
  logic [COLOR_BITS-1:0] g_in;
  logic [COLOR_BITS-1:0] b_in;
  logic                  hsync;
  logic                  vsync;
  logic                  hblank;
  logic                  vblank;
  logic                  de;
  logic [7:0]            r;
  logic [7:0]            g;
  logic [7:0]            b;
  logic                  line_start;
  logic                  frame_start;

  modport master (
    output x, y, req,
    input  r_in, g_in, b_in,
    output hsync, vsync, hblank, vblank, de, r, g, b, line_start, frame_start
  );

  modport slave (
    input  x, y, req,
    output r_in, g_in, b_in,
    input  hsync, vsync, hblank, vblank, de, r, g, b, line_start, frame_start
  );

endinterface

// File: rtl/video_delay_line.sv
// Clock-enabled shift register of depth D with synchronous reset to RESET_VAL.
// D = 0 degenerates to a plain wire.
module video_delay_line #(
  parameter int unsigned  W         = 1,
  parameter int unsigned  D         = 1,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ce_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (D == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_i, ce_i};
    assign q_o = d_i;
  end else begin : g_shift
    logic [W-1:0] stage_q [D];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < D; i++) begin
          stage_q[i] <= RESET_VAL;
        end
      end else if (ce_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < D; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[D-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: issues pixel coordinates to the core, delays timing to match
// the core fetch latency, then expands colour and applies border / test-pattern overlay.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY  = DEF_H_DISPLAY,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_PULSE    = DEF_H_PULSE,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_DISPLAY  = DEF_V_DISPLAY,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_PULSE    = DEF_V_PULSE,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned CW         = 12,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned PIPE       = 2,
  parameter int unsigned COLOR_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce_pix,
  input  logic [1:0]          pattern,
  input  logic                border_en,
  video_timing_gen_if.master  vid
);

  localparam int unsigned H_TOTAL = H_PULSE + H_BP + H_DISPLAY + H_FP;
  localparam int unsigned V_TOTAL = V_PULSE + V_BP + V_DISPLAY + V_FP;
  localparam int unsigned XB      = $clog2(H_DISPLAY);

  localparam logic [CW-1:0] HLast     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HActStart = CW'(H_PULSE + H_BP);
  localparam logic [CW-1:0] HActEnd   = CW'(H_PULSE + H_BP + H_DISPLAY);
  localparam logic [CW-1:0] VActStart = CW'(V_PULSE + V_BP);
  localparam logic [CW-1:0] VActEnd   = CW'(V_PULSE + V_BP + V_DISPLAY);
  localparam logic [CW-1:0] HSyncEnd  = CW'(H_PULSE);
  localparam logic [CW-1:0] VSyncEnd  = CW'(V_PULSE);
  localparam logic [CW-1:0] XLast     = CW'(H_DISPLAY - 1);
  localparam logic [CW-1:0] YLast     = CW'(V_DISPLAY - 1);

  localparam timing_t TimingIdle = '{
    hsync:       ~HS_POL,
    vsync:       ~VS_POL,
    hblank:      1'b1,
    vblank:      1'b1,
    de:          1'b0,
    border:      1'b0,
    bar:         3'd0,
    x_lo:        4'd0,
    y_lo:        4'd0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (ce_pix) begin
      if (h_cnt_q == HLast) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Stage 0: decoded straight from the counter registers.
  logic          h_act, v_act, s0_de;
  logic [CW-1:0] x0, y0;
  timing_t       s0;

  always_comb begin
    h_act = (h_cnt_q >= HActStart) && (h_cnt_q < HActEnd);
    v_act = (v_cnt_q >= VActStart) && (v_cnt_q < VActEnd);
    s0_de = h_act && v_act;
    x0    = s0_de ? (h_cnt_q - HActStart) : '0;
    y0    = s0_de ? (v_cnt_q - VActStart) : '0;

    s0.hsync       = (h_cnt_q < HSyncEnd) ? HS_POL : ~HS_POL;
    s0.vsync       = (v_cnt_q < VSyncEnd) ? VS_POL : ~VS_POL;
    s0.hblank      = ~h_act;
    s0.vblank      = ~v_act;
    s0.de          = s0_de;
    s0.border      = s0_de && ((x0 == '0) || (x0 == XLast) || (y0 == '0) || (y0 == YLast));
    s0.bar         = x0[XB-1 -: 3];
    s0.x_lo        = x0[3:0];
    s0.y_lo        = y0[3:0];
    s0.line_start  = (h_cnt_q == '0);
    s0.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  assign vid.x   = x0;
  assign vid.y   = y0;
  assign vid.req = s0_de;

  timing_t dly;

  video_delay_line #(
    .W         ($bits(timing_t)),
    .D         (PIPE),
    .RESET_VAL (TimingIdle)
  ) u_delay (
    .clk_i (clk),
    .rst_i (reset),
    .ce_i  (ce_pix),
    .d_i   (s0),
    .q_o   (dly)
  );

  pattern_t   pat_q, pat_d;
  logic       border_q, border_d;
  timing_t    out_q, out_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic       white;

  always_comb begin
    pat_d    = pat_q;
    border_d = border_q;
    out_d    = out_q;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    white    = (dly.x_lo == 4'd0) || (dly.y_lo == 4'd0);
    if (ce_pix) begin
      // Overlay controls only change at the top of a frame so a frame is never mixed.
      if (s0.frame_start) begin
        pat_d    = pattern_t'(pattern);
        border_d = border_en;
      end
      out_d = dly;
      if (!dly.de) begin
        r_d = 8'h00;
        g_d = 8'h00;
        b_d = 8'h00;
      end else if (border_q && dly.border) begin
        r_d = 8'hFF;
        g_d = 8'hFF;
        b_d = 8'hFF;
      end else begin
        case (pat_q)
          PAT_BARS: begin
            r_d = {8{dly.bar[0]}};
            g_d = {8{dly.bar[1]}};
            b_d = {8{dly.bar[2]}};
          end
          PAT_GRID: begin
            r_d = {8{white}};
            g_d = {8{white}};
            b_d = {8{white}};
          end
          PAT_SOLID: begin
            r_d = 8'h80;
            g_d = 8'h80;
            b_d = 8'h80;
          end
          default: begin
            r_d = expand_color(8'(vid.r_in), COLOR_BITS);
            g_d = expand_color(8'(vid.g_in), COLOR_BITS);
            b_d = expand_color(8'(vid.b_in), COLOR_BITS);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      pat_q    <= PAT_PASS;
      border_q <= 1'b0;
      out_q    <= TimingIdle;
      r_q      <= 8'h00;
      g_q      <= 8'h00;
      b_q      <= 8'h00;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      pat_q    <= pat_d;
      border_q <= border_d;
      out_q    <= out_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign vid.hsync       = out_q.hsync;
  assign vid.vsync       = out_q.vsync;
  assign vid.hblank      = out_q.hblank;
  assign vid.vblank      = out_q.vblank;
  assign vid.de          = out_q.de;
  assign vid.line_start  = out_q.line_start;
  assign vid.frame_start = out_q.frame_start;
  assign vid.r           = r_q;
  assign vid.g           = g_q;
  assign vid.b           = b_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default raster, inverted-polarity 320x240 raster and a tiny raster
// for frame-level overlay, clock-enable scaling and mid-frame reset.
module tb_video_timing_gen;

  logic       clk = 1'b0;
  logic       reset_ab, ce_ab;
  logic       reset_c, ce_c;
  logic [1:0] pattern_c;
  logic       border_c;

  always #5 clk = ~clk;

  video_timing_gen_if #(.CW(12), .COLOR_BITS(4)) vif_a ();
  video_timing_gen_if #(.CW(12), .COLOR_BITS(4)) vif_b ();
  video_timing_gen_if #(.CW(12), .COLOR_BITS(4)) vif_c ();

  video_timing_gen u_dut_a (
    .clk       (clk),
    .reset     (reset_ab),
    .ce_pix    (ce_ab),
    .pattern   (2'd0),
    .border_en (1'b0),
    .vid       (vif_a)
  );

  video_timing_gen #(
    .H_DISPLAY (320), .H_FP (16), .H_PULSE (32), .H_BP (48),
    .V_DISPLAY (240), .V_FP (3),  .V_PULSE (4),  .V_BP (13),
    .HS_POL    (1'b1), .VS_POL (1'b1)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset_ab),
    .ce_pix    (ce_ab),
    .pattern   (2'd0),
    .border_en (1'b0),
    .vid       (vif_b)
  );

  video_timing_gen #(
    .H_DISPLAY (32), .H_FP (2), .H_PULSE (4), .H_BP (2),
    .V_DISPLAY (16), .V_FP (1), .V_PULSE (2), .V_BP (2)
  ) u_dut_c (
    .clk       (clk),
    .reset     (reset_c),
    .ce_pix    (ce_c),
    .pattern   (pattern_c),
    .border_en (border_c),
    .vid       (vif_c)
  );

  // Core stand-ins: two-tick fetch latency, r = x[3:0], g = ~x[3:0], b = y[3:0].
  logic [23:0] ca1 = '0, ca2 = '0, cc1 = '0, cc2 = '0;
  always @(posedge clk) if (ce_ab) begin ca1 <= {vif_a.y, vif_a.x}; ca2 <= ca1; end
  always @(posedge clk) if (ce_c)  begin cc1 <= {vif_c.y, vif_c.x}; cc2 <= cc1; end
  assign vif_a.r_in = ca2[3:0];
  assign vif_a.g_in = ~ca2[3:0];
  assign vif_a.b_in = ca2[15:12];
  assign vif_c.r_in = cc2[3:0];
  assign vif_c.g_in = ~cc2[3:0];
  assign vif_c.b_in = cc2[15:12];
  assign vif_b.r_in = '0;
  assign vif_b.g_in = '0;
  assign vif_b.b_in = '0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Phase A captures
  int          a_hs0 = 0, a_hs1 = 0, a_first_req = 0, a_first_de = 0, a_de24 = 0, a_de25 = 0;
  logic [11:0] a_x_fr, a_y_fr, a_x10, a_x25, a_y25;
  logic [23:0] a_rgb_m1, a_rgb_0, a_rgb_15, a_rgb_16, a_rgb_255, a_rgb_l25;
  logic        a_fs2, a_fs3, a_fs4, a_ls323, a_ls324, a_hs2, a_hs3, a_hs42, a_hs43;
  int          b_hs_hi = 0, b_rise1 = 0, b_rise2 = 0, b_vs_hi = 0, b_first_de = 0, b_de17 = 0;
  logic        b_hs_prev;
  // Phase B/C captures
  logic [23:0] c_rgb [int];
  logic        c_de168, c_fs843, c_de2928;
  int          c4_hs = 0, c4_de = 0;
  logic        c4_fs8, c4_fs9, c4_fs12, c4_fs13, c4_de672, c4_de673;
  logic [23:0] c4_rgb673, c4_rgb676, c4_rgb677;

  function automatic logic [23:0] rgb_c();
    return {vif_c.r, vif_c.g, vif_c.b};
  endfunction

  initial begin
    reset_ab = 1'b1; ce_ab = 1'b1;
    reset_c = 1'b1; ce_c = 1'b1; pattern_c = 2'd0; border_c = 1'b1;
    repeat (3) @(negedge clk);

    check("a_rst_hsync",  32'(vif_a.hsync), 1);
    check("a_rst_vsync",  32'(vif_a.vsync), 1);
    check("a_rst_blank",  32'({vif_a.hblank, vif_a.vblank}), 32'h3);
    check("a_rst_de",     32'(vif_a.de), 0);
    check("a_rst_rgb",    32'({vif_a.r, vif_a.g, vif_a.b}), 0);
    check("a_rst_pulses", 32'({vif_a.line_start, vif_a.frame_start}), 0);
    check("a_rst_req",    32'(vif_a.req), 0);
    check("b_rst_sync",   32'({vif_b.hsync, vif_b.vsync}), 0);

    // ---------------- Phase A: default and inverted-polarity rasters, ce_pix = 1
    reset_ab  = 1'b0;
    b_hs_prev = vif_b.hsync;
    for (int n = 1; n <= 8330; n++) begin
      @(negedge clk);
      if (n >= 3 && n < 323 && !vif_a.hsync) a_hs0++;
      if (n >= 323 && n < 643 && !vif_a.hsync) a_hs1++;
      if (vif_a.req && a_first_req == 0) begin
        a_first_req = n; a_x_fr = vif_a.x; a_y_fr = vif_a.y;
      end
      if (vif_a.de && a_first_de == 0) a_first_de = n;
      if (vif_a.de && n <= 8002) a_de24++;
      if (vif_a.de && n > 8002 && n <= 8322) a_de25++;
      if (n == 2)    begin a_fs2 = vif_a.frame_start; a_hs2 = vif_a.hsync; end
      if (n == 3)    begin a_fs3 = vif_a.frame_start; a_hs3 = vif_a.hsync; end
      if (n == 4)    a_fs4 = vif_a.frame_start;
      if (n == 42)   a_hs42 = vif_a.hsync;
      if (n == 43)   a_hs43 = vif_a.hsync;
      if (n == 323)  a_ls323 = vif_a.line_start;
      if (n == 324)  a_ls324 = vif_a.line_start;
      if (n == 7746) a_x10 = vif_a.x;
      if (n == 8059) begin a_x25 = vif_a.x; a_y25 = vif_a.y; a_rgb_l25 = {vif_a.r, vif_a.g, vif_a.b}; end
      if (n == 7738) a_rgb_m1  = {vif_a.r, vif_a.g, vif_a.b};
      if (n == 7739) a_rgb_0   = {vif_a.r, vif_a.g, vif_a.b};
      if (n == 7754) a_rgb_15  = {vif_a.r, vif_a.g, vif_a.b};
      if (n == 7755) a_rgb_16  = {vif_a.r, vif_a.g, vif_a.b};
      if (n == 7994) a_rgb_255 = {vif_a.r, vif_a.g, vif_a.b};

      if (n >= 3 && n < 419 && vif_b.hsync) b_hs_hi++;
      if (vif_b.hsync && !b_hs_prev) begin
        if (b_rise1 == 0) b_rise1 = n;
        else if (b_rise2 == 0) b_rise2 = n;
      end
      b_hs_prev = vif_b.hsync;
      if (vif_b.vsync) b_vs_hi++;
      if (vif_b.de && b_first_de == 0) b_first_de = n;
      if (vif_b.de && n <= 7490) b_de17++;
    end

    check("a_hsync_low_line0", a_hs0, 40);
    check("a_hsync_low_line1", a_hs1, 40);
    check("a_hsync_edges", 32'({a_hs2, a_hs3, a_hs42, a_hs43}), 32'b1001);
    check("a_frame_start", 32'({a_fs2, a_fs3, a_fs4}), 32'b010);
    check("a_line_start", 32'({a_ls323, a_ls324}), 32'b10);
    check("a_first_req", a_first_req, 7736);
    check("a_first_xy", 32'({a_x_fr, a_y_fr}), 0);
    check("a_x10", 32'(a_x10), 10);
    check("a_line25_xy", 32'({a_x25, a_y25}), 32'h003001);
    check("a_first_de", a_first_de, 7739);
    check("a_de_line24", a_de24, 256);
    check("a_de_line25", a_de25, 256);
    check("a_rgb_pre_de", 32'(a_rgb_m1), 32'h000000);
    check("a_rgb_x0", 32'(a_rgb_0), 32'h00FF00);
    check("a_rgb_x15", 32'(a_rgb_15), 32'hFF0000);
    check("a_rgb_x16", 32'(a_rgb_16), 32'h00FF00);
    check("a_rgb_x255", 32'(a_rgb_255), 32'hFF0000);
    check("a_rgb_line25", 32'(a_rgb_l25), 32'h00FF11);
    check("b_hsync_high", b_hs_hi, 32);
    check("b_first_hs_rise", b_rise1, 3);
    check("b_line_total", b_rise2 - b_rise1, 416);
    check("b_vsync_high", b_vs_hi, 4 * 416);
    check("b_first_de", b_first_de, 17 * 416 + 80 + 3);
    check("b_de_line17", b_de17, 320);

    // ---------------- Phase B: tiny 40x21 raster, border then patterns frame by frame
    reset_c = 1'b0;
    for (int m = 1; m <= 2932; m++) begin
      @(negedge clk);
      if (m == 168)  c_de168  = vif_c.de;
      if (m == 843)  c_fs843  = vif_c.frame_start;
      if (m == 2928) c_de2928 = vif_c.de;
      if (m == 169 || m == 210 || m == 240 || m == 489 || m == 494 || m == 745 ||
          m == 785 || m == 1013 || m == 1017 || m == 1025 || m == 1037 || m == 1329 ||
          m == 1849 || m == 1889 || m == 1890 || m == 1905 || m == 2928 || m == 2929 ||
          m == 2932)
        c_rgb[m] = rgb_c();
      if (m == 400)  begin pattern_c = 2'd1; border_c = 1'b0; end
      if (m == 1200) pattern_c = 2'd2;
      if (m == 2000) pattern_c = 2'd3;
    end

    check("c_pre_de", 32'(c_de168), 0);
    check("c_border_topleft", 32'(c_rgb[169]), 32'hFFFFFF);
    check("c_interior_x1y1", 32'(c_rgb[210]), 32'h11EE11);
    check("c_border_right", 32'(c_rgb[240]), 32'hFFFFFF);
    check("c_border_held_midframe", 32'(c_rgb[489]), 32'hFFFFFF);
    check("c_pass_held_midframe", 32'(c_rgb[494]), 32'h55AA88);
    check("c_interior_y14", 32'(c_rgb[745]), 32'h00FFEE);
    check("c_border_bottom", 32'(c_rgb[785]), 32'hFFFFFF);
    check("c_frame_start", 32'(c_fs843), 1);
    check("c_bar0_no_border", 32'(c_rgb[1329]), 32'h000000);
    check("c_bar1", 32'(c_rgb[1013]), 32'hFF0000);
    check("c_bar2", 32'(c_rgb[1017]), 32'h00FF00);
    check("c_bar4", 32'(c_rgb[1025]), 32'h0000FF);
    check("c_bar7", 32'(c_rgb[1037]), 32'hFFFFFF);
    check("c_grid_y0", 32'(c_rgb[1849]), 32'hFFFFFF);
    check("c_grid_x0", 32'(c_rgb[1889]), 32'hFFFFFF);
    check("c_grid_off", 32'(c_rgb[1890]), 32'h000000);
    check("c_grid_x16", 32'(c_rgb[1905]), 32'hFFFFFF);
    check("c_solid_blank", 32'({c_de2928, c_rgb[2928]}), 32'h0000000);
    check("c_solid_x0", 32'(c_rgb[2929]), 32'h808080);
    check("c_solid_x3", 32'(c_rgb[2932]), 32'h808080);

    // Mid-frame reset with ce_pix low: reset must still win.
    reset_c = 1'b1; ce_c = 1'b0;
    @(negedge clk);
    check("c_rst_sync", 32'({vif_c.hsync, vif_c.vsync}), 32'b11);
    check("c_rst_de_blank", 32'({vif_c.de, vif_c.hblank, vif_c.vblank}), 32'b011);
    check("c_rst_rgb", 32'(rgb_c()), 0);
    check("c_rst_x", 32'({vif_c.req, vif_c.x}), 0);
    @(negedge clk);

    // ---------------- Phase C: one enable in four after reset release
    reset_c = 1'b0; pattern_c = 2'd0; border_c = 1'b0; ce_c = 1'b1;
    for (int j = 1; j <= 3360; j++) begin
      @(negedge clk);
      if (j <= 160 && !vif_c.hsync) c4_hs++;
      if (vif_c.de) c4_de++;
      if (j == 8)   c4_fs8  = vif_c.frame_start;
      if (j == 9)   c4_fs9  = vif_c.frame_start;
      if (j == 12)  c4_fs12 = vif_c.frame_start;
      if (j == 13)  c4_fs13 = vif_c.frame_start;
      if (j == 672) c4_de672 = vif_c.de;
      if (j == 673) begin c4_de673 = vif_c.de; c4_rgb673 = rgb_c(); end
      if (j == 676) c4_rgb676 = rgb_c();
      if (j == 677) c4_rgb677 = rgb_c();
      ce_c = (j % 4 == 0);
    end

    check("c4_frame_start", 32'({c4_fs8, c4_fs9, c4_fs12, c4_fs13}), 32'b0110);
    check("c4_hsync_low", c4_hs, 16);
    check("c4_de_frame", c4_de, 2048);
    check("c4_first_de", 32'({c4_de672, c4_de673}), 32'b01);
    check("c4_rgb_x0", 32'(c4_rgb673), 32'h00FF00);
    check("c4_rgb_held", 32'(c4_rgb676), 32'h00FF00);
    check("c4_rgb_x1", 32'(c4_rgb677), 32'h11EE00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed 256x256 raster generator: any H/V geometry, selectable sync polarity, clock-enabled pixel rate.
- Issues pixel coordinates to the video core and delays timing to match a configurable core pixel-fetch latency.
- Expands 1..8-bit colour to 8 bits; optionally overlays a white border or a built-in test pattern.
- Sits between the game video core and the framework video output/mixer.

Parameters:
H_DISPLAY, 256, active pixels per line
H_FP, 8, horizontal front porch (pixels)
H_PULSE, 40, hsync width (pixels)
H_BP, 16, horizontal back porch (pixels)
V_DISPLAY, 256, active lines (power of two, >=16)
V_FP, 8, vertical front porch (lines)
V_PULSE, 8, vsync width (lines)
V_BP, 16, vertical back porch (lines)
CW, 12, counter/coordinate width
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level
PIPE, 2, core latency from coordinate to RGB (ce ticks, 0..7)
COLOR_BITS, 4, input colour depth (1..8)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
ce_pix  in  1  pixel clock enable; all state advances only when high (except reset)
pattern  in  2  0 pass-through, 1 colour bars, 2 grid, 3 solid grey
border_en  in  1  white border on outermost active row/column
r_in, g_in, b_in  in  COLOR_BITS each  core pixel for the coordinate issued PIPE ticks earlier
x, y  out  CW each  active coordinate (0 outside active)
req  out  1  x/y valid (active region, stage 0)
hsync, vsync  out  1  sync, polarity per HS_POL/VS_POL
hblank, vblank, de  out  1  aligned with rgb
r, g, b  out  8 each  output colour
line_start, frame_start  out  1  one-ce-tick pulses, aligned with rgb

Behaviour:
- Counters: H_TOTAL = sum of H_*, V_TOTAL = sum of V_*. h_cnt 0..H_TOTAL-1; on wrap h_cnt goes to 0 and v_cnt increments; v_cnt wraps at V_TOTAL-1 to 0.
- Line order: sync [0, H_PULSE-1], back porch, active [H_PULSE+H_BP, +H_DISPLAY-1], front porch. Vertical uses the same order.
- Defaults: H_TOTAL 320, active h_cnt 56..311; V_TOTAL 288, active v_cnt 24..279.
- Stage 0 (combinational from counter registers): req = h-active && v-active; x = h_cnt-(H_PULSE+H_BP) when req, else 0; y likewise.
- Timing delay: stage-0 signals (sync, blank, de, border flag, x/y low bits, line/frame start) pass through a PIPE-deep ce-gated delay line. They are then registered with the RGB selection, so outputs lag the coordinate by PIPE+1 ce ticks.
- RGB inputs are sampled on the same ce tick as the delayed stage-0 signals.
- Colour expansion: replicate input MSB-first to fill 8 bits; COLOR_BITS=4 gives {c,c}.
- Output select priority, evaluated in order:
  - de=0 -> 0.
  - Border active -> 8'hFF on all channels.
  - pattern 1: bar = x[top 3 bits of log2(H_DISPLAY)]; r=bar[0], g=bar[1], b=bar[2], each bit replicated to 8'hFF/8'h00.
  - pattern 2: white where x[3:0]==0 or y[3:0]==0, else black.
  - pattern 3: 8'h80 on all channels.
  - pattern 0: expanded input.
- Border flag = de && (x==0 || x==H_DISPLAY-1 || y==0 || y==V_DISPLAY-1).
- pattern and border_en are latched only on the ce tick where h_cnt=0 && v_cnt=0. A mid-frame change takes effect from the next frame.
- line_start: h_cnt==0 (stage 0), delayed. frame_start: h_cnt==0 && v_cnt==0, delayed.
- Reset values: counters 0; delay line cleared to the blank/inactive state; hsync=!HS_POL, vsync=!VS_POL; hblank=vblank=1; de=0; rgb=0; pulses=0; latched pattern=0, border=0.
- Reset dominates ce_pix. Reset mid-frame restarts the raster at h=v=0 on the next clk.
- ce_pix low: all registers hold, including the delay line; outputs are frozen.
- Simultaneous h and v wrap: both counters go to 0 on the same ce tick.

Decomposition:
- Package video_timing_pkg:
  - pattern_t enum (PAT_PASS, PAT_BARS, PAT_GRID, PAT_SOLID);
  - default timing constants;
  - function expand_color(value, bits) returning 8 bits.
- Sub-module video_delay_line: width W, depth D (D=0 is a wire), ce-gated shift register with synchronous reset to a RESET_VAL parameter.

Test Plan:
- Defaults, ce_pix=1, PIPE=2: hsync low for 40 clks of every 320. First de=1 three clks after req rises, with x=0 issued at h_cnt=56. 256 de clks per line; 256 de lines per 288.
- pattern=0, COLOR_BITS=4, core returns r_in=x[3:0] with 2-tick latency: r sequence 00,11,22,...,FF repeating, exactly aligned with de.
- border_en=1, pattern=0: first/last active columns and first/last active lines output FFFFFF; interior passes input.
- pattern switched 0->1 mid-frame: current frame unchanged; next frame shows 8 bars of 32 px, bar 7 = FFFFFF, bar 0 = 000000.
- ce_pix toggled 1-of-4: all period counts scale by 4 and outputs are held between enables. Reset asserted at v_cnt=100 returns hsync/vsync inactive, de=0, rgb=0 next clk, then frame_start fires PIPE+1 ticks after release.
- HS_POL=1, VS_POL=1, geometry 320x240 with porches 16/32/48 and 3/4/13: sync pulses invert, line totals 416/260 verified.
